// File: rtl/audio_out_pkg.sv
// Shared widths, mute FSM states and the sample-to-duty conversion for pwm_audio_out.
package audio_out_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PWM_W    = 8;
  localparam int SHIFT_W  = 4;
  localparam logic [PWM_W-1:0] MIDSCALE = 8'h80;

  // RAMP_DOWN/RAMP_UP are only reachable with PWM_AUDIO_SOFT_MUTE_EN.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } mute_state_t;

  // Scale by an arithmetic shift, then keep the top PWM_W bits in offset binary.
  function automatic logic [PWM_W-1:0] to_level(input logic signed [SAMPLE_W-1:0] sample,
                                                input logic [SHIFT_W-1:0]         shift);
    logic signed [SAMPLE_W-1:0] s;
    s = sample >>> shift;
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: PWM_W-1]};
  endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Sample stream from the fir63 filter into pwm_audio_out.
// A sample transfers on every clock edge where sample_valid_in && sample_ready_out;
// ready never depends on valid, and a valid sample offered while ready is low is dropped.
interface pwm_audio_out_if;
  import audio_out_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid_in;
  logic                       sample_ready_out;

  modport master (output sample_in, output sample_valid_in, input sample_ready_out);
  modport slave  (input sample_in, input sample_valid_in, output sample_ready_out);
endinterface

// File: rtl/pwm_audio_out_sync_fifo.sv
// Single-clock FIFO with show-ahead head output; DEPTH must be a power of 2 and >= 2.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM speaker output stage: FIFO-buffered samples, volume shift, mute FSM, registered PWM bit.
// Define PWM_AUDIO_SOFT_MUTE_EN for a stepped attenuation ramp instead of hard mute.
module pwm_audio_out
  import audio_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  pwm_audio_out_if.slave     s_if,
  input  logic [2:0]         vol_in,
  input  logic               mute_in,
  output logic               pwm_out,
  output logic               aud_sd_out,
  output logic [PWM_W-1:0]   level_out,
  output logic               overflow_out,
  output mute_state_t        mute_state_out
);

  logic [PWM_W-1:0]           r_count;
  logic                       r_en;
  logic                       r_pwm;
  logic                       r_overflow;
  logic [PWM_W-1:0]           r_level;
  mute_state_t                r_state;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_boundary;
  logic signed [SAMPLE_W-1:0] w_head;
  logic [SHIFT_W-1:0]         w_vol_shift;

  assign w_boundary            = (r_count == {PWM_W{1'b1}});
  assign s_if.sample_ready_out = r_en && !w_full;
  assign w_push                = s_if.sample_valid_in && s_if.sample_ready_out;
  assign w_pop                 = w_boundary && !w_empty;
  assign w_vol_shift           = {1'b0, 3'd7 - vol_in};

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_wr_en   (w_push),
    .i_wr_data (s_if.sample_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // r_en holds ready and amp enable low until the first edge after reset release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count    <= '0;
      r_en       <= 1'b0;
      r_pwm      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= r_count + PWM_W'(1);
      r_en    <= 1'b1;
      r_pwm   <= (r_count < r_level);
      if (s_if.sample_valid_in && !s_if.sample_ready_out) r_overflow <= 1'b1;
    end
  end

`ifdef PWM_AUDIO_SOFT_MUTE_EN
  logic [3:0]                 r_att;
  logic [3:0]                 w_att_next;
  mute_state_t                w_state_next;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic signed [SAMPLE_W-1:0] w_cur;
  logic [SHIFT_W-1:0]         w_shift;
  logic                       w_reload;

  // A mute_in change mid-ramp just flips direction from the current att.
  always_comb begin
    w_state_next = r_state;
    w_att_next   = r_att;
    case (r_state)
      RUN: begin
        if (mute_in) begin
          w_state_next = RAMP_DOWN;
          w_att_next   = 4'd1;
        end
      end
      RAMP_DOWN, RAMP_UP: begin
        if (mute_in) begin
          w_att_next   = r_att + 4'd1;
          w_state_next = (r_att == 4'd7) ? MUTED : RAMP_DOWN;
        end else begin
          w_att_next   = r_att - 4'd1;
          w_state_next = (r_att == 4'd1) ? RUN : RAMP_UP;
        end
      end
      MUTED: begin
        if (!mute_in) begin
          w_state_next = RAMP_UP;
          w_att_next   = 4'd7;
        end
      end
      default: begin
        w_state_next = RUN;
        w_att_next   = 4'd0;
      end
    endcase
  end

  assign w_cur    = w_pop ? w_head : r_sample;
  assign w_shift  = w_vol_shift + w_att_next;
  assign w_reload = w_pop || (r_state != RUN) || (w_state_next != RUN);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= RUN;
      r_att    <= 4'd0;
      r_sample <= '0;
      r_level  <= MIDSCALE;
    end else if (w_boundary) begin
      r_state <= w_state_next;
      r_att   <= w_att_next;
      if (w_pop) r_sample <= w_head;
      if (w_att_next == 4'd8) r_level <= MIDSCALE;
      else if (w_reload)      r_level <= to_level(w_cur, w_shift);
    end
  end
`else
  // Pops continue while muted so the upstream filter never stalls.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= RUN;
      r_level <= MIDSCALE;
    end else if (w_boundary) begin
      case (r_state)
        RUN:     if (mute_in)  r_state <= MUTED;
        MUTED:   if (!mute_in) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (mute_in)    r_level <= MIDSCALE;
      else if (w_pop) r_level <= to_level(w_head, w_vol_shift);
    end
  end
`endif

  assign pwm_out        = r_pwm;
  assign aud_sd_out     = r_en;
  assign level_out      = r_level;
  assign overflow_out   = r_overflow;
  assign mute_state_out = r_state;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: expected duty levels are queued per accepted sample
// and popped at each carrier boundary.
module tb_pwm_audio_out;
  import audio_out_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       vol;
  logic             mute;
  logic             pwm;
  logic             aud_sd;
  logic [PWM_W-1:0] level;
  logic             ovf;
  mute_state_t      state;

  pwm_audio_out_if s_if ();

  pwm_audio_out #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .s_if           (s_if),
    .vol_in         (vol),
    .mute_in        (mute),
    .pwm_out        (pwm),
    .aud_sd_out     (aud_sd),
    .level_out      (level),
    .overflow_out   (ovf),
    .mute_state_out (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0] tb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 8'd0;
    else        tb_cnt <= tb_cnt + 8'd1;
  end

  // scoreboard
  logic [PWM_W-1:0] exp_q[$];
  logic [PWM_W-1:0] last_level;
  logic             muted_model;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [7:0] model_level(input logic [15:0] s, input int shift);
    int v;
    v = int'(signed'(s)) >>> shift;
    v = v + 32768;
    return v[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [7:0] n);
    int k = 0;
    do begin tick(); k++; end while (tb_cnt != n && k < 300);
    check("wait_count_timeout", 32'(tb_cnt), 32'(n));
  endtask

  task automatic wait_boundary();
    int k = 0;
    do begin tick(); k++; end while (tb_cnt != 8'd0 && k < 300);
    check("boundary_timeout", 32'(tb_cnt), 32'd0);
  endtask

  task automatic at_boundary(input string tag);
    if (exp_q.size() > 0) last_level = exp_q.pop_front();
    if (muted_model) last_level = MIDSCALE;
    check(tag, 32'(level), 32'(last_level));
  endtask

  task automatic push(input logic [15:0] s, input logic [7:0] lvl, input string tag);
    s_if.sample_in       = s;
    s_if.sample_valid_in = 1'b1;
    check({tag, "_ready"}, 32'(s_if.sample_ready_out), 32'(exp_q.size() < FIFO_DEPTH));
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(lvl);
    tick();
    s_if.sample_valid_in = 1'b0;
  endtask

  task automatic count_high(input string tag, input int exp);
    int h = 0;
    repeat (256) begin
      tick();
      h += int'(pwm);
    end
    check(tag, 32'(h), 32'(exp));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] down_tbl [8];
  logic [15:0] ovf_s [5];

  initial begin
    rst_n = 1'b0; vol = 3'd7; mute = 1'b0; muted_model = 1'b0;
    s_if.sample_in = '0; s_if.sample_valid_in = 1'b0;
    last_level = MIDSCALE;

    // reset values
    repeat (3) tick();
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_sd", 32'(aud_sd), 32'd0);
    check("rst_ready", 32'(s_if.sample_ready_out), 32'd0);
    check("rst_level", 32'(level), 32'h80);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(state), 32'(RUN));
    rst_n = 1'b1;
    #1;
    check("rel_sd_before_edge", 32'(aud_sd), 32'd0);
    tick();
    check("rel_sd", 32'(aud_sd), 32'd1);
    check("rel_ready", 32'(s_if.sample_ready_out), 32'd1);

    // idle: mid-scale square wave
    wait_boundary();
    for (int p = 0; p < 4; p++) begin
      at_boundary("idle_level");
      count_high("idle_duty", 128);
    end
    at_boundary("idle_level_end");

    // full scale positive and negative
    vol = 3'd7;
    wait_count(8'd10);
    push(16'h7FFF, 8'hFF, "max_pos");
    wait_boundary();
    at_boundary("max_pos_level");
    count_high("max_pos_duty", 255);
    at_boundary("max_pos_hold");
    wait_count(8'd10);
    push(16'h8000, 8'h00, "max_neg");
    wait_boundary();
    at_boundary("max_neg_level");
    count_high("max_neg_duty", 0);
    at_boundary("max_neg_hold");

    // volume scaling
    vol = 3'd6;
    wait_count(8'd10);
    push(16'h7FFF, 8'hBF, "vol6");
    wait_boundary();
    at_boundary("vol6_level");
    vol = 3'd0;
    wait_count(8'd10);
    push(16'h7FFF, 8'h80, "vol0");
    wait_boundary();
    at_boundary("vol0_level");
    vol = 3'd3;
    wait_count(8'd10);
    push(16'h1234, model_level(16'h1234, 4), "vol3");
    wait_boundary();
    at_boundary("vol3_level");
    vol = 3'd5;
    wait_count(8'd10);
    push(16'hC000, model_level(16'hC000, 2), "vol5_neg");
    wait_boundary();
    at_boundary("vol5_neg_level");
    count_high("vol5_neg_duty", int'(model_level(16'hC000, 2)));
    at_boundary("vol5_neg_hold");

    // overflow: five back-to-back pushes into a depth-4 FIFO
    vol = 3'd7;
    ovf_s[0] = 16'h1000; ovf_s[1] = 16'h2000; ovf_s[2] = 16'h3000;
    ovf_s[3] = 16'h4000; ovf_s[4] = 16'h5000;
    wait_count(8'd10);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before", 32'(ovf), 32'd0);
      push(ovf_s[i], model_level(ovf_s[i], 0), "burst");
    end
    check("ovf_sticky", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_boundary();
      at_boundary("burst_order");
      check("burst_ready", 32'(s_if.sample_ready_out), 32'(exp_q.size() < FIFO_DEPTH));
    end
    check("ovf_still", 32'(ovf), 32'd1);

    // mute
    wait_count(8'd10);
    push(16'h7FFF, 8'hFF, "pre_mute");
    wait_boundary();
    at_boundary("pre_mute_level");
`ifdef PWM_AUDIO_SOFT_MUTE_EN
    down_tbl[0] = 8'hBF; down_tbl[1] = 8'h9F; down_tbl[2] = 8'h8F; down_tbl[3] = 8'h87;
    down_tbl[4] = 8'h83; down_tbl[5] = 8'h81; down_tbl[6] = 8'h80; down_tbl[7] = 8'h80;
    wait_count(8'd20);
    mute = 1'b1;
    for (int a = 1; a <= 8; a++) begin
      wait_boundary();
      check("soft_down_level", 32'(level), 32'(down_tbl[a-1]));
      check("soft_down_state", 32'(state), 32'((a == 8) ? MUTED : RAMP_DOWN));
    end
    wait_boundary();
    check("soft_muted_level", 32'(level), 32'h80);
    check("soft_muted_state", 32'(state), 32'(MUTED));
    mute = 1'b0;
    for (int a = 7; a >= 0; a--) begin
      wait_boundary();
      check("soft_up_level", 32'(level), 32'(model_level(16'h7FFF, a)));
      check("soft_up_state", 32'(state), 32'((a == 0) ? RUN : RAMP_UP));
    end
    mute = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      wait_boundary();
      check("soft_part_down", 32'(level), 32'(model_level(16'h7FFF, a)));
    end
    mute = 1'b0;
    for (int a = 3; a >= 0; a--) begin
      wait_boundary();
      check("soft_reverse", 32'(level), 32'(model_level(16'h7FFF, a)));
      check("soft_reverse_state", 32'(state), 32'((a == 0) ? RUN : RAMP_UP));
    end
    last_level = 8'hFF;
`else
    wait_count(8'd20);
    mute = 1'b1;
    muted_model = 1'b1;
    push(16'h2000, model_level(16'h2000, 0), "muted_push");
    wait_boundary();
    at_boundary("hard_mute_level");
    check("hard_mute_state", 32'(state), 32'(MUTED));
    count_high("hard_mute_duty", 128);
    at_boundary("hard_mute_hold");
    check("muted_drained_ready", 32'(s_if.sample_ready_out), 32'd1);
    mute = 1'b0;
    muted_model = 1'b0;
    wait_boundary();
    at_boundary("unmute_level");
    check("unmute_state", 32'(state), 32'(RUN));
    wait_count(8'd10);
    push(16'h7FFF, 8'hFF, "post_mute");
    wait_boundary();
    at_boundary("post_mute_level");
`endif

    // asynchronous reset mid-period with three queued samples
    wait_count(8'd10);
    push(16'h1000, 8'h90, "rst_fill");
    push(16'h2000, 8'hA0, "rst_fill");
    push(16'h3000, 8'hB0, "rst_fill");
    wait_count(8'd100);
    check("pre_rst_pwm", 32'(pwm), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm), 32'd0);
    check("arst_sd", 32'(aud_sd), 32'd0);
    check("arst_ready", 32'(s_if.sample_ready_out), 32'd0);
    check("arst_level", 32'(level), 32'h80);
    check("arst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    last_level = MIDSCALE;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(s_if.sample_ready_out), 32'd1);
    wait_boundary();
    at_boundary("post_rst_empty");
    count_high("post_rst_duty", 128);
    at_boundary("post_rst_hold");
    wait_count(8'd10);
    push(16'h4000, 8'hC0, "post_rst_push");
    wait_boundary();
    at_boundary("post_rst_fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
